// File: rtl/manchester_pkg.sv
// manchester_pkg
// Shared definitions for the Manchester receiver / framer:
//   rx_state_t      - framer state (HUNT: searching for sync word, DATA: packing payload)
//   window_start()  - first phase value at which a mid-bit edge is accepted (3*spb/4)
//   timeout_phase() - phase value that signals loss of signal (2*spb-1)
//   ctr_w()         - counter width able to index 0..n-1 (never narrower than 1 bit)
package manchester_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        DATA = 1'b1
    } rx_state_t;

    function automatic int window_start(input int spb);
        return (3 * spb) / 4;
    endfunction

    function automatic int timeout_phase(input int spb);
        return 2 * spb - 1;
    endfunction

    function automatic int ctr_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/manchester_bit_recovery.sv
// manchester_bit_recovery
// Recovers Manchester bits from an asynchronous, oversampled line.
//   aclk, aresetn  - clock, synchronous active-low reset
//   manchester_in  - asynchronous line input
//   bit_valid      - one-cycle strobe: a mid-bit edge was accepted this cycle
//   bit_value      - recovered bit, valid with bit_valid (new level XOR INVERT)
//   timeout        - one-cycle strobe: no accepted edge for 2*SAMPLES_PER_BIT-1 cycles
// Optional macro MANCHESTER_RX_GLITCH_FILTER_EN inserts a 3-sample majority
// filter after the synchroniser (rejects 1-cycle pulses, adds 2 cycles latency).
module manchester_bit_recovery
    import manchester_pkg::*;
#(
    parameter int SAMPLES_PER_BIT = 8,
    parameter bit INVERT          = 1'b0
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic manchester_in,
    output logic bit_valid,
    output logic bit_value,
    output logic timeout
);

    localparam int PHASE_W = ctr_w(2 * SAMPLES_PER_BIT);
    localparam logic [PHASE_W-1:0] WIN_START = PHASE_W'(window_start(SAMPLES_PER_BIT));
    localparam logic [PHASE_W-1:0] PHASE_MAX = PHASE_W'(timeout_phase(SAMPLES_PER_BIT));
    localparam logic [PHASE_W-1:0] PHASE_PRE = PHASE_W'(timeout_phase(SAMPLES_PER_BIT) - 1);

    logic               sync_q1;
    logic               sync_q2;
    logic               line_level;
    logic               prev_level;
    logic [PHASE_W-1:0] phase;
    logic               edge_seen;
    logic               window_open;
    logic               accept;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= manchester_in;
            sync_q2 <= sync_q1;
        end
    end

`ifdef MANCHESTER_RX_GLITCH_FILTER_EN
    logic hist1;
    logic hist2;
    logic filt_q;

    // Majority of three consecutive samples; a lone 1-cycle pulse never wins.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            hist1  <= 1'b0;
            hist2  <= 1'b0;
            filt_q <= 1'b0;
        end else begin
            hist1  <= sync_q2;
            hist2  <= hist1;
            filt_q <= (sync_q2 & hist1) | (sync_q2 & hist2) | (hist1 & hist2);
        end
    end

    assign line_level = filt_q;
`else
    assign line_level = sync_q2;
`endif

    // Before the first accepted edge (or after a timeout) there is no bit
    // timing yet, so any edge is taken as a mid-bit edge to acquire phase.
    assign window_open = !edge_seen || (phase >= WIN_START);
    assign accept      = (line_level ^ prev_level) && window_open;

    assign bit_valid = accept;
    assign bit_value = line_level ^ INVERT;
    // Strobes on the cycle the phase counter steps onto its saturation value.
    assign timeout   = !accept && (phase == PHASE_PRE);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            prev_level <= 1'b0;
            phase      <= '0;
            edge_seen  <= 1'b0;
        end else begin
            prev_level <= line_level;
            if (accept) begin
                phase <= '0;
            end else if (phase != PHASE_MAX) begin
                phase <= phase + 1'b1;
            end
            if (accept) begin
                edge_seen <= 1'b1;
            end else if (timeout) begin
                edge_seen <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/manchester_rx_framer.sv
// manchester_rx_framer
// Manchester receiver with sync-word framing and an AXI-Stream master output.
//   aclk, aresetn  - clock, synchronous active-low reset
//   manchester_in  - asynchronous oversampled line
//   m_axis_tdata   - payload word (MSB received first)
//   m_axis_tvalid  - word valid
//   m_axis_tready  - downstream ready
//   m_axis_tlast   - last word of frame
//   m_axis_tuser   - first word of frame (SOF)
//   sync_locked    - high while the framer is in DATA (exposes FSM state)
//   rx_err         - one-cycle pulse on loss of signal during DATA
//   overflow       - sticky: a completed word was dropped; cleared by reset only
// Optional macro MANCHESTER_RX_GLITCH_FILTER_EN enables the line majority filter
// inside manchester_bit_recovery.
module manchester_rx_framer
    import manchester_pkg::*;
#(
    parameter int               DATA_W          = 8,
    parameter int               SAMPLES_PER_BIT = 8,
    parameter int               SYNC_W          = 8,
    parameter logic [SYNC_W-1:0] SYNC_WORD      = 8'hD5,
    parameter int               FRAME_WORDS     = 4,
    parameter bit               INVERT          = 1'b0
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              manchester_in,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              m_axis_tuser,
    output logic              sync_locked,
    output logic              rx_err,
    output logic              overflow
);

    localparam int BIT_CNT_W  = ctr_w(DATA_W);
    localparam int WORD_CNT_W = ctr_w(FRAME_WORDS);
    localparam int SYNC_CNT_W = ctr_w(SYNC_W + 1);
    localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(DATA_W - 1);
    localparam logic [WORD_CNT_W-1:0] LAST_WORD = WORD_CNT_W'(FRAME_WORDS - 1);
    localparam logic [SYNC_CNT_W-1:0] SYNC_FULL = SYNC_CNT_W'(SYNC_W);

    logic bit_valid;
    logic bit_value;
    logic timeout;

    manchester_bit_recovery #(
        .SAMPLES_PER_BIT (SAMPLES_PER_BIT),
        .INVERT          (INVERT)
    ) u_bit_recovery (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .manchester_in (manchester_in),
        .bit_valid     (bit_valid),
        .bit_value     (bit_value),
        .timeout       (timeout)
    );

    rx_state_t              state;
    logic [SYNC_W-1:0]      sync_sr;
    logic [SYNC_CNT_W-1:0]  sync_cnt;
    logic [DATA_W-1:0]      data_sr;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [WORD_CNT_W-1:0]  word_cnt;

    logic [SYNC_W:0]        sync_ext;
    logic [SYNC_W-1:0]      sync_next;
    logic [SYNC_CNT_W-1:0]  sync_cnt_next;
    logic                   sync_hit;
    logic [DATA_W:0]        data_ext;
    logic [DATA_W-1:0]      word_next;
    logic                   word_done;
    logic                   word_last;

    assign sync_ext      = {sync_sr, bit_value};
    assign sync_next     = sync_ext[SYNC_W-1:0];
    assign sync_cnt_next = (sync_cnt == SYNC_FULL) ? sync_cnt : sync_cnt + 1'b1;
    // The bit-count guard stops a match against zeros left over from a clear.
    assign sync_hit      = (sync_next == SYNC_WORD) && (sync_cnt_next == SYNC_FULL);
    assign data_ext      = {data_sr, bit_value};
    assign word_next     = data_ext[DATA_W-1:0];
    assign word_done     = bit_valid && (state == DATA) && (bit_cnt == LAST_BIT);
    assign word_last     = (word_cnt == LAST_WORD);

    assign sync_locked = (state == DATA);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state    <= HUNT;
            sync_sr  <= '0;
            sync_cnt <= '0;
            data_sr  <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            rx_err   <= 1'b0;
        end else begin
            rx_err <= 1'b0;
            if (timeout) begin
                // Loss of signal: drop any partial word and start hunting afresh.
                rx_err   <= (state == DATA);
                state    <= HUNT;
                sync_sr  <= '0;
                sync_cnt <= '0;
                data_sr  <= '0;
                bit_cnt  <= '0;
                word_cnt <= '0;
            end else if (bit_valid) begin
                case (state)
                    HUNT: begin
                        sync_sr  <= sync_next;
                        sync_cnt <= sync_cnt_next;
                        if (sync_hit) begin
                            state    <= DATA;
                            bit_cnt  <= '0;
                            word_cnt <= '0;
                        end
                    end
                    DATA: begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            data_sr <= '0;
                            if (word_last) begin
                                state    <= HUNT;
                                sync_sr  <= '0;
                                sync_cnt <= '0;
                                word_cnt <= '0;
                            end else begin
                                word_cnt <= word_cnt + 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            data_sr <= word_next;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    // Handshake: a beat transfers on a rising aclk edge where tvalid && tready.
    // Once tvalid is high, tdata/tlast/tuser hold until that transfer; a word
    // completing while the held beat is stalled is dropped and flagged in
    // overflow. A word completing in the transfer cycle replaces the beat.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            overflow      <= 1'b0;
        end else if (word_done) begin
            if (!m_axis_tvalid || m_axis_tready) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= word_next;
                m_axis_tuser  <= (word_cnt == '0);
                m_axis_tlast  <= word_last;
            end else begin
                overflow <= 1'b1;
            end
        end else if (m_axis_tvalid && m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_manchester_rx_framer.sv
module tb_manchester_rx_framer;

    localparam int SPB  = 8;
    localparam int HALF = SPB / 2;

    logic aclk = 1'b0;
    logic aresetn;
    logic line_raw;
    logic m_axis_tready;
    logic line_n;
    logic line_i;

    // Non-inverting receiver sees the raw line, inverting receiver its complement.
    assign line_n = line_raw;
    assign line_i = ~line_raw;

    logic [7:0] tdata_n, tdata_i;
    logic       tvalid_n, tvalid_i;
    logic       tlast_n, tlast_i;
    logic       tuser_n, tuser_i;
    logic       locked_n, locked_i;
    logic       rx_err_n, rx_err_i;
    logic       ovf_n, ovf_i;

    manchester_rx_framer #(
        .DATA_W(8), .SAMPLES_PER_BIT(SPB), .SYNC_W(8), .SYNC_WORD(8'hD5),
        .FRAME_WORDS(2), .INVERT(1'b0)
    ) dut_n (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .manchester_in (line_n),
        .m_axis_tdata  (tdata_n),
        .m_axis_tvalid (tvalid_n),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (tlast_n),
        .m_axis_tuser  (tuser_n),
        .sync_locked   (locked_n),
        .rx_err        (rx_err_n),
        .overflow      (ovf_n)
    );

    manchester_rx_framer #(
        .DATA_W(8), .SAMPLES_PER_BIT(SPB), .SYNC_W(8), .SYNC_WORD(8'hD5),
        .FRAME_WORDS(2), .INVERT(1'b1)
    ) dut_i (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .manchester_in (line_i),
        .m_axis_tdata  (tdata_i),
        .m_axis_tvalid (tvalid_i),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (tlast_i),
        .m_axis_tuser  (tuser_i),
        .sync_locked   (locked_i),
        .rx_err        (rx_err_i),
        .overflow      (ovf_i)
    );

    // ---------------- clock / reset ----------------
    always #5 aclk = ~aclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- scoreboard ----------------
    logic [9:0] exp_n_q[$];
    logic [9:0] exp_i_q[$];
    int err_n = 0;
    int err_i = 0;

    task automatic expect_beat(input logic sof, input logic eof, input logic [7:0] d);
        exp_n_q.push_back({sof, eof, d});
        exp_i_q.push_back({sof, eof, d});
    endtask

    always @(negedge aclk) begin
        logic [9:0] e;
        #2;
        if (rx_err_n) err_n++;
        if (rx_err_i) err_i++;
        if (tvalid_n && m_axis_tready) begin
            check("beat_n_expected", 32'(exp_n_q.size() > 0), 32'd1);
            if (exp_n_q.size() > 0) begin
                e = exp_n_q.pop_front();
                check("beat_n", {22'd0, tuser_n, tlast_n, tdata_n}, {22'd0, e});
            end
        end
        if (tvalid_i && m_axis_tready) begin
            check("beat_i_expected", 32'(exp_i_q.size() > 0), 32'd1);
            if (exp_i_q.size() > 0) begin
                e = exp_i_q.pop_front();
                check("beat_i", {22'd0, tuser_i, tlast_i, tdata_i}, {22'd0, e});
            end
        end
    end

    // ---------------- driver tasks ----------------
    bit jit_long = 1'b0;

    task automatic tick(input int n);
        repeat (n) @(negedge aclk);
    endtask

    // IEEE 802.3 encoding on the raw line: first half ~b, second half b.
    // With glitch set, a 1-cycle pulse lands 3 cycles into the second half.
    task automatic send_bit(input logic b, input int h1, input int h2, input bit glitch);
        line_raw = ~b;
        tick(h1);
        line_raw = b;
        if (glitch) begin
            tick(3);
            line_raw = ~b;
            tick(1);
            line_raw = b;
            tick(h2 - 4);
        end else begin
            tick(h2);
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i], HALF, HALF, 1'b0);
    endtask

    // Mid-bit spacing alternates 7/9 cycles; the long halves carry a glitch.
    task automatic send_byte_jit(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i], HALF, jit_long ? HALF + 1 : HALF - 1, jit_long);
            jit_long = !jit_long;
        end
    endtask

    task automatic idle(input int n);
        line_raw = 1'b1;
        tick(n);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        tick(5);
        aresetn = 1'b1;
        idle(30);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] any_n;
        logic [31:0] any_i;
        int          lat_n, lat_i;
        int          err_cyc_n, err_cyc_i;

        aresetn       = 1'b0;
        line_raw      = 1'b1;
        m_axis_tready = 1'b1;

        // Reset: line toggling while held in reset, outputs must stay low.
        any_n = 0;
        any_i = 0;
        for (int c = 0; c < 50; c++) begin
            line_raw = 1'($urandom_range(0, 1));
            tick(1);
            any_n |= {tdata_n, tvalid_n, tlast_n, tuser_n, locked_n, rx_err_n, ovf_n};
            any_i |= {tdata_i, tvalid_i, tlast_i, tuser_i, locked_i, rx_err_i, ovf_i};
        end
        check("reset_outputs_n", any_n, 32'd0);
        check("reset_outputs_i", any_i, 32'd0);
        check("reset_locked_n", 32'(locked_n), 32'd0);
        check("reset_locked_i", 32'(locked_i), 32'd0);
        aresetn = 1'b1;
        idle(30);

        // Clean frame with latency measurement on the last bit of word 0.
        expect_beat(1'b1, 1'b0, 8'hA5);
        expect_beat(1'b0, 1'b1, 8'h3C);
        send_byte(8'h55);
        send_byte(8'hD5);
        check("locked_after_sync_n", 32'(locked_n), 32'd1);
        check("locked_after_sync_i", 32'(locked_i), 32'd1);
        for (int i = 7; i >= 1; i--) send_bit(1'(8'hA5 >> i), HALF, HALF, 1'b0);
        line_raw = 1'b0;
        tick(HALF);
        line_raw = 1'b1;
        lat_n = 0;
        lat_i = 0;
        for (int c = 1; c <= HALF; c++) begin
            tick(1);
            if (tvalid_n && lat_n == 0) lat_n = c;
            if (tvalid_i && lat_i == 0) lat_i = c;
        end
        check("latency_n", 32'(lat_n), 32'd3);
        check("latency_i", 32'(lat_i), 32'd3);
        send_byte(8'h3C);
        idle(40);
        check("clean_done_n", 32'(exp_n_q.size()), 32'd0);
        check("clean_done_i", 32'(exp_i_q.size()), 32'd0);
        check("clean_unlocked_n", 32'(locked_n), 32'd0);
        check("clean_unlocked_i", 32'(locked_i), 32'd0);
        check("clean_rx_err_n", 32'(err_n), 32'd0);
        check("clean_rx_err_i", 32'(err_i), 32'd0);
        check("clean_overflow_n", 32'(ovf_n), 32'd0);

        // Backpressure: first word held, second dropped, overflow set.
        m_axis_tready = 1'b0;
        expect_beat(1'b1, 1'b0, 8'hA5);
        send_byte(8'h55);
        send_byte(8'hD5);
        send_byte(8'hA5);
        check("bp_held_data_mid_n", 32'(tdata_n), 32'hA5);
        send_byte(8'h3C);
        idle(20);
        check("bp_tvalid_n", 32'(tvalid_n), 32'd1);
        check("bp_held_n", {22'd0, tuser_n, tlast_n, tdata_n}, {22'd0, 2'b10, 8'hA5});
        check("bp_held_i", {22'd0, tuser_i, tlast_i, tdata_i}, {22'd0, 2'b10, 8'hA5});
        check("bp_overflow_n", 32'(ovf_n), 32'd1);
        check("bp_overflow_i", 32'(ovf_i), 32'd1);
        m_axis_tready = 1'b1;
        tick(3);
        check("bp_drained_n", 32'(tvalid_n), 32'd0);
        check("bp_drained_i", 32'(tvalid_i), 32'd0);
        check("bp_queue_n", 32'(exp_n_q.size()), 32'd0);
        check("bp_queue_i", 32'(exp_i_q.size()), 32'd0);
        check("bp_overflow_sticky_n", 32'(ovf_n), 32'd1);

        do_reset();
        check("overflow_cleared_n", 32'(ovf_n), 32'd0);
        check("overflow_cleared_i", 32'(ovf_i), 32'd0);

        // Signal loss after 3 data bits: rx_err 18 cycles after the last transition.
        send_byte(8'h55);
        send_byte(8'hD5);
        send_bit(1'b1, HALF, HALF, 1'b0);
        send_bit(1'b0, HALF, HALF, 1'b0);
        line_raw = 1'b0;
        tick(HALF);
        line_raw = 1'b1;
        err_cyc_n = 0;
        err_cyc_i = 0;
        for (int c = 1; c <= 30; c++) begin
            tick(1);
            if (rx_err_n && err_cyc_n == 0) err_cyc_n = c;
            if (rx_err_i && err_cyc_i == 0) err_cyc_i = c;
        end
        check("loss_rx_err_cycle_n", 32'(err_cyc_n), 32'd18);
        check("loss_rx_err_cycle_i", 32'(err_cyc_i), 32'd18);
        check("loss_rx_err_count_n", 32'(err_n), 32'd1);
        check("loss_rx_err_count_i", 32'(err_i), 32'd1);
        check("loss_unlocked_n", 32'(locked_n), 32'd0);
        check("loss_no_beat_n", 32'(tvalid_n), 32'd0);
        idle(10);

        expect_beat(1'b1, 1'b0, 8'h0F);
        expect_beat(1'b0, 1'b1, 8'hF0);
        send_byte(8'h55);
        send_byte(8'hD5);
        send_byte(8'h0F);
        send_byte(8'hF0);
        idle(40);
        check("recover_queue_n", 32'(exp_n_q.size()), 32'd0);
        check("recover_queue_i", 32'(exp_i_q.size()), 32'd0);

        // Jitter (7/9 spacing) with glitches at phase 2.
        expect_beat(1'b1, 1'b0, 8'h96);
        expect_beat(1'b0, 1'b1, 8'h69);
        jit_long = 1'b0;
        send_byte_jit(8'h55);
        send_byte_jit(8'hD5);
        send_byte_jit(8'h96);
        send_byte_jit(8'h69);
        idle(40);
        check("jitter_queue_n", 32'(exp_n_q.size()), 32'd0);
        check("jitter_queue_i", 32'(exp_i_q.size()), 32'd0);
        check("jitter_rx_err_n", 32'(err_n), 32'd1);
        check("jitter_rx_err_i", 32'(err_i), 32'd1);
        check("final_overflow_n", 32'(ovf_n), 32'd0);
        check("final_overflow_i", 32'(ovf_i), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
